// File: rtl/wptr_full_ctrl_pkg.sv
// rtl/wptr_full_ctrl_pkg.sv - shared Gray-code helpers and depth derivation for the FIFO pointer controllers
package wptr_full_ctrl_pkg;

    function automatic int depth_of(input int addr_bits);
        return 1 << addr_bits;
    endfunction

    function automatic logic [31:0] width_mask(input int width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b, input int width);
        logic [31:0] bm;
        bm = b & width_mask(width);
        return bm ^ (bm >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int width);
        logic [31:0] gm;
        logic [31:0] b;
        gm = g & width_mask(width);
        b  = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(gm >> i);
        end
        return b;
    endfunction

    // Gray value the write pointer holds when it is exactly one lap ahead of g.
    function automatic logic [31:0] gray_full_target(input logic [31:0] g, input int width);
        return (g ^ (32'd3 << (width - 2))) & width_mask(width);
    endfunction

endpackage

// File: rtl/wptr_full_ctrl_ptr_sync_2ff.sv
// rtl/wptr_full_ctrl_ptr_sync_2ff.sv - two-flop synchroniser for a Gray pointer crossing into the local clock
module ptr_sync_2ff #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q1_q;
    logic [WIDTH-1:0] q2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= d_i;
            q2_q <= q1_q;
        end
    end

    assign q_o = q2_q;

endmodule

// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - write-side pointer, full/almost-full, fill level and sticky overflow for the async FIFO
module wptr_full_ctrl
    import wptr_full_ctrl_pkg::*;
#(
    parameter int Address   = 2,
    parameter int AF_MARGIN = 1
) (
    input  logic             w_clk,
    input  logic             w_rst_n,
    input  logic             w_en,
    input  logic             ovf_clr,
    input  logic [Address:0] r_ptr_gray,
    output logic [Address:0] w_addr,
    output logic [Address:0] w_ptr_gray,
    output logic             full,
    output logic             almost_full,
    output logic [Address:0] w_level,
    output logic             overflow
);

    localparam int PW    = Address + 1;
    localparam int DEPTH = depth_of(Address);
    localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] rq2;
    logic [PW-1:0] w_bin_q,  w_bin_d;
    logic [PW-1:0] w_gray_q, w_gray_d;
    logic [PW-1:0] level_q,  level_d;
    logic [PW-1:0] r_bin;
    logic          full_q,   full_d;
    logic          af_q,     af_d;
    logic          ovf_q,    ovf_d;
    logic          wr_ok;

    ptr_sync_2ff #(
        .WIDTH (PW)
    ) u_rptr_sync (
        .clk_i   (w_clk),
        .rst_n_i (w_rst_n),
        .d_i     (r_ptr_gray),
        .q_o     (rq2)
    );

    always_comb begin
        wr_ok    = w_en & ~full_q;
        w_bin_d  = w_bin_q + PW'(wr_ok);
        w_gray_d = PW'(bin2gray(32'(w_bin_d), PW));
        r_bin    = PW'(gray2bin(32'(rq2), PW));
        // Level uses the stale synchronised read pointer, so it can only over-report.
        level_d  = w_bin_d - r_bin;
        full_d   = (w_gray_d == PW'(gray_full_target(32'(rq2), PW)));
        af_d     = (level_d >= AF_THRESH);
        ovf_d    = (w_en & full_q) | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            w_bin_q  <= '0;
            w_gray_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            w_bin_q  <= w_bin_d;
            w_gray_q <= w_gray_d;
            level_q  <= level_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    assign w_addr      = w_bin_q;
    assign w_ptr_gray  = w_gray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign w_level     = level_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb/tb_wptr_full_ctrl.sv - self-checking bench for wptr_full_ctrl (Address=2, AF_MARGIN=1)
module tb_wptr_full_ctrl;

    typedef struct {
        logic [2:0] addr;
        logic [2:0] gray;
        logic       full;
        logic       af;
        logic [2:0] lvl;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       clr;
        logic [2:0] rptr;
        exp_t       e;
    } vec_t;

    logic       w_clk = 1'b0;
    logic       w_rst_n = 1'b0;
    logic       w_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [2:0] r_ptr_gray = 3'b000;
    logic [2:0] w_addr;
    logic [2:0] w_ptr_gray;
    logic       full;
    logic       almost_full;
    logic [2:0] w_level;
    logic       overflow;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];
    vec_t vecs[14];
    logic [2:0] gray_tab[8];

    wptr_full_ctrl #(
        .Address   (2),
        .AF_MARGIN (1)
    ) dut (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .w_en        (w_en),
        .ovf_clr     (ovf_clr),
        .r_ptr_gray  (r_ptr_gray),
        .w_addr      (w_addr),
        .w_ptr_gray  (w_ptr_gray),
        .full        (full),
        .almost_full (almost_full),
        .w_level     (w_level),
        .overflow    (overflow)
    );

    always #5 w_clk = ~w_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    function automatic exp_t mk(input logic [2:0] a, input logic [2:0] g, input logic f,
                                input logic af, input logic [2:0] l, input logic o);
        exp_t e;
        e.addr = a; e.gray = g; e.full = f; e.af = af; e.lvl = l; e.ovf = o;
        return e;
    endfunction

    // Drive one edge's inputs, queue its expectation, then compare after the edge.
    task automatic step(input string tag, input logic rst_n, input logic en, input logic clr,
                        input logic [2:0] rptr, input exp_t e);
        exp_t got;
        w_rst_n = rst_n; w_en = en; ovf_clr = clr; r_ptr_gray = rptr;
        sb_q.push_back(e);
        @(posedge w_clk);
        #1;
        got = sb_q.pop_front();
        chk({tag, ".w_addr"},      int'(w_addr),      int'(got.addr));
        chk({tag, ".w_ptr_gray"},  int'(w_ptr_gray),  int'(got.gray));
        chk({tag, ".full"},        int'(full),        int'(got.full));
        chk({tag, ".almost_full"}, int'(almost_full), int'(got.af));
        chk({tag, ".w_level"},     int'(w_level),     int'(got.lvl));
        chk({tag, ".overflow"},    int'(overflow),    int'(got.ovf));
    endtask

    initial begin
        logic [2:0] prev_gray;
        logic [2:0] diff;
        int         k;

        gray_tab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

        //            rst  en   clr  rptr      addr  gray   full af  lvl   ovf
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 3'b000, mk(3'd0, 3'b000, 0, 0, 3'd0, 0)};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 3'b000, mk(3'd0, 3'b000, 0, 0, 3'd0, 0)};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 3'b000, mk(3'd1, 3'b001, 0, 0, 3'd1, 0)};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'b000, mk(3'd2, 3'b011, 0, 0, 3'd2, 0)};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'b000, mk(3'd3, 3'b010, 0, 1, 3'd3, 0)};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'b000, mk(3'd4, 3'b110, 1, 1, 3'd4, 0)};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b000, mk(3'd4, 3'b110, 1, 1, 3'd4, 1)};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'b000, mk(3'd4, 3'b110, 1, 1, 3'd4, 1)};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 3'b000, mk(3'd4, 3'b110, 1, 1, 3'd4, 0)};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 3'b000, mk(3'd4, 3'b110, 1, 1, 3'd4, 1)};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 3'b001, mk(3'd4, 3'b110, 1, 1, 3'd4, 1)};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 3'b001, mk(3'd4, 3'b110, 1, 1, 3'd4, 1)};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 3'b001, mk(3'd4, 3'b110, 0, 1, 3'd3, 1)};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 3'b001, mk(3'd4, 3'b110, 0, 1, 3'd3, 0)};

        @(negedge w_clk);
        for (int i = 0; i < 14; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].en, vecs[i].clr,
                 vecs[i].rptr, vecs[i].e);
        end

        // Wrap: reader follows the live write pointer, so it trails by the two sync stages.
        step("wrap_rst", 1'b0, 1'b0, 1'b0, 3'b000, mk(3'd0, 3'b000, 0, 0, 3'd0, 0));
        prev_gray = 3'b000;
        for (int i = 1; i <= 10; i++) begin
            k = (i < 3) ? i : 3;
            step($sformatf("wrap%0d", i), 1'b1, 1'b1, 1'b0, w_ptr_gray,
                 mk(3'(i % 8), gray_tab[i % 8], 0, (k >= 3), 3'(k), 0));
            diff = w_ptr_gray ^ prev_gray;
            chk($sformatf("wrap%0d.gray_bits_toggled", i), $countones(diff), 1);
            prev_gray = w_ptr_gray;
        end

        // Reset while full, then a single write restarts from address 0.
        step("rf_rst", 1'b0, 1'b0, 1'b0, 3'b000, mk(3'd0, 3'b000, 0, 0, 3'd0, 0));
        step("rf_w1",  1'b1, 1'b1, 1'b0, 3'b000, mk(3'd1, 3'b001, 0, 0, 3'd1, 0));
        step("rf_w2",  1'b1, 1'b1, 1'b0, 3'b000, mk(3'd2, 3'b011, 0, 0, 3'd2, 0));
        step("rf_w3",  1'b1, 1'b1, 1'b0, 3'b000, mk(3'd3, 3'b010, 0, 1, 3'd3, 0));
        step("rf_w4",  1'b1, 1'b1, 1'b0, 3'b000, mk(3'd4, 3'b110, 1, 1, 3'd4, 0));
        step("rf_ovf", 1'b1, 1'b1, 1'b0, 3'b000, mk(3'd4, 3'b110, 1, 1, 3'd4, 1));
        step("rf_rst2", 1'b0, 1'b1, 1'b0, 3'b000, mk(3'd0, 3'b000, 0, 0, 3'd0, 0));
        step("rf_post", 1'b1, 1'b1, 1'b0, 3'b000, mk(3'd1, 3'b001, 0, 0, 3'd1, 0));

        chk("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
- Write-side pointer and full-flag controller for the asynchronous FIFO; sits directly upstream of the dual-clock memory stage.
- Drives the memory's write address and full qualifier.
- Synchronises the read-domain Gray pointer into the write clock domain and produces full, almost-full, fill level and a sticky overflow flag.
- Exports the registered Gray write pointer for the read-side controller.

Parameters:
- Address, 2, number of memory address bits; DEPTH = 2**Address; legal range Address >= 1.
- AF_MARGIN, 1, almost_full threshold margin; legal range 1 <= AF_MARGIN < DEPTH.

Ports:
- w_clk  input  1  write-domain clock; all logic on its rising edge.
- w_rst_n  input  1  reset, synchronous, active-low.
- w_en  input  1  write request from producer.
- ovf_clr  input  1  clears the sticky overflow flag.
- r_ptr_gray  input  Address+1  read pointer in Gray code from the read domain; asynchronous to w_clk.
- w_addr  output  Address+1  binary write pointer to memory. Low Address bits index the memory; the MSB is the wrap bit.
- w_ptr_gray  output  Address+1  registered Gray write pointer for read-side synchronisation.
- full  output  1  FIFO full, registered; feeds the memory's full input.
- almost_full  output  1  registered; w_level >= DEPTH-AF_MARGIN.
- w_level  output  Address+1  registered write-side fill estimate, 0..DEPTH.
- overflow  output  1  sticky; set on a write attempt while full.

Behaviour:
- Reset: w_rst_n=0 at a rising edge of w_clk zeroes all state, overriding every other input on that edge.
  - State zeroed: w_bin, w_ptr_gray, sync flops rq1/rq2, full, almost_full, w_level, overflow.
  - No asynchronous reset path.
- Synchroniser: rq1 <= r_ptr_gray; rq2 <= rq1.
  - Two-flop chain, no logic between the flops.
  - Only the Gray value crosses domains.
- Accept: wr_ok = w_en & ~full.
  - w_bin_next = w_bin + wr_ok, mod 2**(Address+1).
  - w_gray_next = w_bin_next ^ (w_bin_next >> 1).
  - Each edge: w_bin <= w_bin_next; w_ptr_gray <= w_gray_next.
- w_addr = w_bin (registered). The memory writes at the same edge the pointer advances, using the pre-increment address.
- full <= (w_gray_next == {~rq2[Address:Address-1], rq2[Address-2:0]}).
  - Compare uses the current rq2, before this edge's update.
  - For Address=1, both bits of rq2 are inverted.
- w_level <= w_bin_next - gray2bin(rq2), mod 2**(Address+1).
  - Invariant: full == (w_level == DEPTH) every cycle.
- almost_full <= (w_bin_next - gray2bin(rq2)) >= DEPTH-AF_MARGIN.
- overflow: set when w_en & full; cleared when ovf_clr & ~(w_en & full). Set wins over clear.
- Latency:
  - Write to full/w_level update: 1 edge.
  - Read pointer change to full deassert / w_level decrease: 3 w_clk edges (2 sync + 1 register).
  - The estimate is pessimistic only: never reports fewer entries than actually stored.
- Wrap-around: the pointer wraps from 2**(Address+1)-1 to 0. Gray code changes exactly one bit per accepted write.
- Write while full: pointer and Gray are unchanged, memory is not written, overflow is set.
- Reset mid-operation: the pointer returns to 0. The read domain must be reset concurrently; this is a system-level requirement, not checked here.

Decomposition:
- Shared package holds:
  - bin2gray and gray2bin functions, parameterised on width.
  - DEPTH derivation.
  - The full-compare helper (top-two-bit inversion).
- One natural sub-module: ptr_sync_2ff, a width-parameterised two-flop synchroniser with synchronous active-low reset.
  - It is reused by the read-side empty controller.

Test Plan:
Configuration for all scenarios: Address=2, DEPTH=4, AF_MARGIN=1.
- Reset: w_rst_n=0 for 2 edges with w_en=1 -> w_addr=0, w_ptr_gray=000, full=0, almost_full=0, w_level=0, overflow=0.
- Fill, r_ptr_gray=000 constant, w_en=1 for 4 edges:
  - w_addr=1,2,3,4.
  - w_ptr_gray=001,011,010,110.
  - almost_full=1 after the 3rd edge; full=1 and w_level=4 after the 4th.
- Overflow: full with w_en=1 for 2 more edges -> w_addr stays 4, overflow=1. Then ovf_clr=1, w_en=0 -> overflow=0 next edge. ovf_clr=1 and w_en=1 while full -> overflow stays 1.
- Drain visibility: from full, set r_ptr_gray=001 -> full=0 and w_level=3 exactly on the 3rd edge, not earlier.
- Wrap: 10 writes with r_ptr_gray tracking w_ptr_gray, delayed 2 writes:
  - w_addr goes 7->0 and w_ptr_gray goes 100->000.
  - Only one Gray bit toggles per write.
  - full never asserts.
- Reset while full: w_rst_n=0 for 1 edge -> all outputs 0 on that edge; a write the next edge gives w_addr=1.
